pipe_hazard_ctrl: RTL

//  Drives the write_i/flush_i controls of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB)
//  and the PC write enable; it is the control end of the pipe-register stall/flush interface.

---
 rtl/pipe_hazard_ctrl.sv | 74 +++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush control for load-use, taken-branch and multi-cycle memory hazards, with saturating perf counters, memory-timeout flag; ports: clk_i, rst_i (async low), ID/EX hazard inputs, memory req/ack, pipe-register write/flush enables, stall_cnt_o, flush_cnt_o, err_o
module pipe_hazard_ctrl #(
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [RA_W-1:0]  ifid_rs_i,
  input  logic [RA_W-1:0]  ifid_rt_i,
  input  logic             ifid_use_rt_i,
  input  logic             idex_memread_i,
  input  logic [RA_W-1:0]  idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_flush_o,
  output logic             exmem_write_o,
  output logic             memwb_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o
);
  localparam int WW = $clog2(MEM_TMO + 1);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] MWAIT = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             err_q, err_d;
  logic             mem_wait, br, lu;
  always_comb begin
    mem_wait      = rst_i & mem_req_i & ~mem_ack_i;
    br            = rst_i & branch_taken_i & ~mem_wait;
    lu            = rst_i & ~mem_wait & ~branch_taken_i & idex_memread_i & (|idex_rt_i) &
                    ((idex_rt_i == ifid_rs_i) | (ifid_use_rt_i & (idex_rt_i == ifid_rt_i)));
    pc_write_o    = ~(mem_wait | lu);
    ifid_write_o  = ~(mem_wait | lu);
    idex_write_o  = ~mem_wait;
    exmem_write_o = ~mem_wait;
    memwb_flush_o = mem_wait;
    ifid_flush_o  = br;
    idex_flush_o  = br | lu;
    state_d       = mem_wait ? MWAIT : RUN;
    // first wait cycle counts as 1 so the flag fires on the MEM_TMO+1-th unacked edge
    wcnt_d        = !mem_wait ? '0 : (state_q == RUN) ? WW'(1) :
                    (wcnt_q == WW'(MEM_TMO)) ? wcnt_q : wcnt_q + WW'(1);
    err_d         = err_q | (mem_wait & (wcnt_q == WW'(MEM_TMO)));
    stall_d       = (!pc_write_o && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d       = (br && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
    stall_cnt_o   = stall_q;
    flush_cnt_o   = flush_q;
    err_o         = err_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end
endmodule
